// File: rtl/rv_pkg.sv
// Shared RV32I core definitions used by the front-end stages.
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO with flush; head is visible combinationally on dout.
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, issues imem reads, buffers returned words for
// decode, and drops responses that belong to fetches squashed by a redirect.
module if_stage
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(FIFO_DEPTH);
  // Stale responses can accumulate across several redirects on a slow memory.
  localparam int DW = CW + 4;
  localparam logic [CW+1:0] DEPTH_C = (CW+2)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic          run_q;
  logic [DW-1:0] discard, discard_tot;
  logic [CW:0]   rq_count, fb_count;
  logic          rq_empty, fb_empty;
  logic [31:0]   rq_pc;
  fetch_entry_t  fb_din, fb_dout;
  logic          grant, rsp_drop, rsp_keep, id_pop;
  logic [CW+1:0] used;

  assign id_valid = !fb_empty && !redirect_valid;
  assign id_pop   = id_valid && id_ready;

  // Slots reserved = in flight + buffered; a slot freed by decode this cycle may
  // be reissued at once, which keeps a 1-cycle memory streaming every cycle.
  assign used      = (CW+2)'(rq_count) + (CW+2)'(fb_count) - (CW+2)'(id_pop);
  assign imem_req  = run_q && !redirect_valid && (used < DEPTH_C);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;

  assign rsp_drop    = imem_rvalid && (redirect_valid || discard != '0);
  assign rsp_keep    = imem_rvalid && !rsp_drop && !rq_empty;
  assign discard_tot = discard + DW'(rq_count);
  assign fb_din      = {rq_pc, imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      fetch_pc <= RESET_PC;
      discard  <= '0;
    end else begin
      run_q <= 1'b1;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        discard  <= discard_tot - DW'(imem_rvalid && discard_tot != '0);
      end else begin
        if (grant)    fetch_pc <= fetch_pc + 32'd4;
        if (rsp_drop) discard  <= discard - 1'b1;
      end
    end
  end

  if_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_req_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant),
    .din   (fetch_pc),
    .pop   (rsp_keep),
    .flush (redirect_valid),
    .dout  (rq_pc),
    .count (rq_count),
    .empty (rq_empty)
  );

  if_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep),
    .din   (fb_din),
    .pop   (id_pop),
    .flush (redirect_valid),
    .dout  (fb_dout),
    .count (fb_count),
    .empty (fb_empty)
  );

  assign id_inst = id_valid ? fb_dout.inst : INST_NOP;
  assign id_pc   = id_valid ? fb_dout.pc : '0;
  assign id_pc4  = id_pc + 32'd4;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: cycle table, directed redirect/reset sequences, random run
// against an in-order instruction-stream reference model.
module tb_if_stage;
  localparam logic [31:0] TAG   = 32'hA5A5_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 2;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready, redirect_valid;
  logic [31:0] id_inst, id_pc, id_pc4, redirect_pc;

  logic        w_rst_n = 1'b1;
  logic        w_req, w_gnt, w_rvalid, w_id_valid, w_id_ready, w_redir;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc, w_pc4, w_rpc;
  logic        w_pend = 1'b0;
  logic [31:0] w_pend_addr = '0;
  logic [31:0] w_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
  int          w_gcnt = 0, w_dcnt = 0;

  int          checks = 0, errors = 0, cyc = 0, live = 0, hs_cnt = 0;
  int          lat_min = 1, lat_max = 1;
  logic        hold_rsp = 1'b0, stall_prev = 1'b0, found;
  logic [31:0] exp_pc = '0, exp_fetch = '0;
  mreq_t       mq[$];
  vec_t        tbl[20];

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .id_pc4(id_pc4), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .id_valid(w_id_valid), .id_ready(w_id_ready), .id_inst(w_inst), .id_pc(w_pc),
    .id_pc4(w_pc4), .redirect_valid(w_redir), .redirect_pc(w_rpc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, update the reference model.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc, input logic gnt);
    @(negedge clk);
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!hold_rsp && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].addr ^ TAG;
      mq.delete(0);
    end
    imem_gnt = gnt; id_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    w_rvalid = w_pend; w_rdata = w_pend_addr ^ TAG;
    #1;
    if (rst_n) begin
      if (!id_valid) chk("nop_when_idle", id_inst, NOP);
      if (redir) begin
        chk("redir_no_valid", 32'(id_valid), 32'd0);
        chk("redir_no_req", 32'(imem_req), 32'd0);
      end else if (stall_prev) chk("stall_hold_valid", 32'(id_valid), 32'd1);
      if (id_valid) begin
        chk("id_pc", id_pc, exp_pc);
        chk("id_inst", id_inst, exp_pc ^ TAG);
        chk("id_pc4", id_pc4, exp_pc + 32'd4);
      end
      if (id_valid && id_ready) begin
        exp_pc = exp_pc + 32'd4; live--; hs_cnt++;
      end
      if (imem_req && imem_gnt) begin
        chk("fetch_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4; live++;
        mq.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
      end
      if (redir) begin
        exp_pc = rpc & 32'hFFFF_FFFC; exp_fetch = exp_pc; live = 0;
      end
      chk("issue_bound", 32'(live <= DEPTH), 32'd1);
      stall_prev = id_valid && !id_ready;
    end
    if (w_req && w_gcnt < 4) begin
      chk("wrap_addr", w_addr, w_exp[w_gcnt]); w_gcnt++;
    end
    if (w_id_valid && w_dcnt < 4) begin
      chk("wrap_pc", w_pc, w_exp[w_dcnt]);
      chk("wrap_pc4", w_pc4, w_exp[w_dcnt] + 32'd4);
      chk("wrap_inst", w_inst, w_exp[w_dcnt] ^ TAG);
      w_dcnt++;
    end
    w_pend = w_req; w_pend_addr = w_addr;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    for (int i = 6; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    tbl[16] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[17] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
    tbl[18] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h18};
    tbl[19] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h1C};

    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    w_gnt = 1'b1; w_id_ready = 1'b1; w_redir = 1'b0; w_rpc = '0;
    w_rvalid = 1'b0; w_rdata = '0;
    #1 rst_n = 1'b0; w_rst_n = 1'b0;

    // reset values
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_inst", id_inst, NOP);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc4, 32'h4);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    rst_n = 1'b1; w_rst_n = 1'b1;

    // cycle table: stream, 10-cycle stall, resume
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rdy, 1'b0, 32'h0, 1'b1);
      chk($sformatf("t%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("t%0d_valid", i), 32'(id_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("t%0d_pc", i), id_pc, tbl[i].pc);
        chk($sformatf("t%0d_inst", i), id_inst, tbl[i].pc ^ TAG);
      end
    end
    chk("wrap_delivered", 32'(w_dcnt), 32'd4);

    // redirect with two requests in flight
    hold_rsp = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("a_inflight", 32'(mq.size()), 32'd2);
    chk("a_idle", 32'(id_valid), 32'd0);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    hold_rsp = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      if (id_valid) begin
        found = 1'b1;
        chk("a_first_pc", id_pc, 32'h0000_0100);
      end
    end
    chk("a_found", 32'(found), 32'd1);

    // redirect coinciding with a response
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    chk("b_rvalid_same_cycle", 32'(imem_rvalid), 32'd1);
    chk("b_valid", 32'(id_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      if (id_valid) begin
        found = 1'b1;
        chk("b_first_pc", id_pc, 32'h0000_0200);
      end
    end
    chk("b_found", 32'(found), 32'd1);

    // random traffic
    lat_min = 1; lat_max = 3;
    begin
      int hs0;
      hs0 = hs_cnt;
      for (int i = 0; i < 1500; i++)
        step($urandom_range(3, 0) != 0, $urandom_range(31, 0) == 0, $urandom,
             $urandom_range(3, 0) != 0);
      chk("rand_progress", 32'(hs_cnt - hs0 > 150), 32'd1);
    end

    // async reset with the buffer full
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c_full_valid", 32'(id_valid), 32'd1);
    chk("c_full_req", 32'(imem_req), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("c_rst_req", 32'(imem_req), 32'd0);
    chk("c_rst_addr", imem_addr, 32'h0);
    chk("c_rst_valid", 32'(id_valid), 32'd0);
    chk("c_rst_inst", id_inst, NOP);
    chk("c_rst_pc", id_pc, 32'h0);
    chk("c_rst_pc4", id_pc4, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
